perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
//  Parametrised bank of NUM_CTR performance counters for the pipelined MIPS core.
//  Each counter is configured at run time with an event source, a count mode (level/edge) and an enable.
//  Event sources come from core status: cycle, instruction retired, load-use stall, MUL stall, branch taken, and so on.
//  32-bit read port feeds the writeback result mux. A 64-bit counter is read as lo then hi.
//  The hi word is latched when lo is read, so a lo/hi pair never tears.
// PARAMETERS
//  NUM_CTR   4   number of counters (2..16)
//  NUM_EVT   8   number of event inputs (2..32); evt[0] is tied to 1 externally (cycle count)
//  CTR_W     64  counter width (33..64); the hi word is zero-extended upper CTR_W-32 bits
//  SATURATE  0   0: wrap to 0 on overflow; 1: hold at all-ones on overflow
// PORTS
//  clk       in   1                 clock, all logic on posedge
//  reset_n   in   1                 asynchronous, active-low reset
//  evt       in   NUM_EVT           event inputs, sampled every cycle
//  freeze    in   1                 global freeze; while 1 no counter changes
//  cfg_we    in   1                 config write strobe
//  cfg_idx   in   $clog2(NUM_CTR)   counter selected by the config write
//  cfg_sel   in   $clog2(NUM_EVT)   event source for that counter
//  cfg_mode  in   2                 00 off, 01 level, 10 rising edge, 11 reserved (treated as off)
//  cfg_clr   in   1                 with cfg_we: zero the counter and its ovf flag
//  rd_en     in   1                 read request
//  rd_idx    in   $clog2(NUM_CTR)   counter to read
//  rd_hi     in   1                 0: read lo word (and latch hi); 1: return the latched hi
//  rd_data   out  32                read data, valid while rd_valid=1
//  rd_valid  out  1                 1-cycle pulse, one cycle after rd_en
//  ovf       out  NUM_CTR           sticky per-counter overflow flags
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - All counters, sel, mode, ovf, hi latch, evt_prev, rd_data and rd_valid go to 0.
//   - All counters are off after reset.
//   - Reset asserted mid-count or mid-read discards the pending rd_valid.
//  Increment condition for counter i, evaluated each cycle:
//   - Requires freeze=0.
//   - mode=01: increment when evt[sel] is 1.
//   - mode=10: increment when evt[sel] is 1 and evt_prev[sel] is 0.
//   - Increment is +1 per cycle at most.
//  Edge detection:
//   - evt_prev is a register of evt, updated every cycle, including during freeze.
//   - An edge that occurs during freeze is therefore lost.
//  Overflow, when the counter is all-ones and increments:
//   - SATURATE=0: counter becomes 0 and ovf[i] sets.
//   - SATURATE=1: counter holds at all-ones and ovf[i] sets.
//   - ovf[i] stays set until a cfg_clr on counter i.
//  Config write (cfg_we=1):
//   - sel and mode are updated at the clock edge; the new config takes effect from the next cycle.
//   - The increment in the write cycle uses the old config.
//   - With cfg_clr=1, the counter and ovf[i] are set to 0. Clear wins over a same-cycle increment and over overflow.
//   - cfg_clr=1 with cfg_we=0 is ignored.
//  Read, with 1-cycle latency:
//   - rd_en=1 at cycle t gives rd_valid=1 and rd_data at cycle t+1.
//   - rd_hi=0: rd_data = ctr[rd_idx][31:0], sampled at the t edge before that cycle's increment.
//   - rd_hi=0 also sets hi_latch = ctr[rd_idx][CTR_W-1:32] from the same sample.
//   - rd_hi=1: rd_data = hi_latch; rd_idx is ignored.
//   - With rd_en=0: rd_valid=0 and rd_data holds its last value.
//   - There is one hi_latch shared by all counters; a later lo read of any counter overwrites it.
//  Simultaneous read and config:
//   - Read and config writes to the same counter in one cycle: the read returns the pre-write value.
//  Index range:
//   - Out-of-range cfg_idx or rd_idx (NUM_CTR not a power of two): writes are ignored; reads return 0.
//   - Out-of-range cfg_sel selects constant 0.
// TESTING
//  T1 cycle count:
//   - Stimulus: reset; cfg ctr0 sel=0 mode=01; wait 100 cycles; read lo.
//   - Expect: rd_data=100 or 101 (exact value per latency), then monotonic.
//  T2 edge mode:
//   - Stimulus: ctr1 sel=3 mode=10; evt[3] held high for 5 cycles, 3 times.
//   - Expect: ctr1=3. The same pattern with mode=01 gives 15.
//  T3 wrap and saturate:
//   - Stimulus: CTR_W=33, preload via 2^33-2 level increments (or a force); run 3 more increments.
//   - Expect with SATURATE=0: ctr=1, ovf=1.
//   - Expect with SATURATE=1: ctr=0x1_FFFF_FFFF, ovf=1.
//   - A cfg_clr in the same cycle as the overflow gives ctr=0, ovf=0.
//  T4 tear-free read:
//   - Stimulus: ctr at 0x0000_0000_FFFF_FFFF counting each cycle; read lo, then hi 3 cycles later.
//   - Expect: lo=0xFFFF_FFFF, hi=0 (latched), even though the live hi is 1.
//  T5 freeze:
//   - Stimulus: freeze=1 for 10 cycles during counting.
//   - Expect: counter unchanged; a rising edge that occurs inside the freeze window is not counted after release.
//  T6 async reset:
//   - Stimulus: drop reset_n mid-cycle with rd_en=1.
//   - Expect: immediately all counters, ovf and rd_valid are 0, and the read response is lost.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Bank of run-time configurable performance counters with a 32-bit read port.
// A lo read latches the upper word so a following hi read returns a consistent pair.
module perf_counter_bank #(
  parameter int NUM_CTR  = 4,
  parameter int NUM_EVT  = 8,
  parameter int CTR_W    = 64,
  parameter int SATURATE = 0,
  localparam int IDX_W   = $clog2(NUM_CTR),
  localparam int SEL_W   = $clog2(NUM_EVT)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               freeze,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_clr,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic               rd_hi,
  output logic [31:0]        rd_data,
  output logic               rd_valid,
  output logic [NUM_CTR-1:0] ovf
);

  localparam logic [1:0] MODE_LEVEL = 2'b01;
  localparam logic [1:0] MODE_EDGE  = 2'b10;

  logic [NUM_CTR-1:0][CTR_W-1:0] ctr;
  logic [NUM_CTR-1:0][SEL_W-1:0] sel;
  logic [NUM_CTR-1:0][1:0]       mode;
  logic [NUM_EVT-1:0]            evt_prev;
  logic [31:0]                   hi_latch;
  logic [NUM_CTR-1:0]            inc;
  logic [NUM_CTR-1:0]            cfg_hit;
  logic [CTR_W-1:0]              rd_word;
  logic [63:0]                   rd_ext;

  // Selects with an index outside the event vector read as constant 0.
  function automatic logic pick(input logic [NUM_EVT-1:0] v, input logic [SEL_W-1:0] s);
    logic r;
    r = 1'b0;
    for (int e = 0; e < NUM_EVT; e++) begin
      if (s == SEL_W'(e)) r = v[e];
    end
    return r;
  endfunction

  always_comb begin
    inc     = '0;
    cfg_hit = '0;
    rd_word = '0;
    for (int i = 0; i < NUM_CTR; i++) begin
      cfg_hit[i] = cfg_we && (cfg_idx == IDX_W'(i));
      inc[i] = !freeze &&
               (((mode[i] == MODE_LEVEL) && pick(evt, sel[i])) ||
                ((mode[i] == MODE_EDGE) && pick(evt, sel[i]) && !pick(evt_prev, sel[i])));
      if (rd_idx == IDX_W'(i)) rd_word = ctr[i];
    end
    rd_ext = 64'(rd_word);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctr      <= '0;
      sel      <= '0;
      mode     <= '0;
      ovf      <= '0;
      evt_prev <= '0;
      hi_latch <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      evt_prev <= evt;
      rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_hi) begin
          rd_data <= hi_latch;
        end else begin
          rd_data  <= rd_ext[31:0];
          hi_latch <= rd_ext[63:32];
        end
      end
      for (int i = 0; i < NUM_CTR; i++) begin
        if (cfg_hit[i]) begin
          sel[i]  <= cfg_sel;
          mode[i] <= cfg_mode;
        end
        // A clear beats both a same-cycle increment and the overflow it would cause.
        if (cfg_hit[i] && cfg_clr) begin
          ctr[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (inc[i]) begin
          if (&ctr[i]) begin
            ovf[i] <= 1'b1;
            if (SATURATE == 0) ctr[i] <= '0;
          end else begin
            ctr[i] <= ctr[i] + CTR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a wrapping and a saturating instance driven in parallel,
// read responses checked against per-instance expectation queues.
module tb_perf_counter_bank;
  localparam int NC = 3;
  localparam int NE = 6;
  localparam int CW = 33;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [NE-1:0] evt;
  logic          freeze, cfg_we, cfg_clr, rd_en, rd_hi;
  logic [1:0]    cfg_idx, rd_idx, cfg_mode;
  logic [2:0]    cfg_sel;
  logic [31:0]   rd_data, rd_data_s;
  logic          rd_valid, rd_valid_s;
  logic [NC-1:0] ovf, ovf_s;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_s_q[$];
  logic [31:0] got_exp, got_exp_s;

  perf_counter_bank #(.NUM_CTR(NC), .NUM_EVT(NE), .CTR_W(CW), .SATURATE(0)) dut (
    .clk(clk), .reset_n(reset_n), .evt(evt), .freeze(freeze), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cfg_clr(cfg_clr),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_hi(rd_hi), .rd_data(rd_data),
    .rd_valid(rd_valid), .ovf(ovf));

  perf_counter_bank #(.NUM_CTR(NC), .NUM_EVT(NE), .CTR_W(CW), .SATURATE(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .evt(evt), .freeze(freeze), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cfg_clr(cfg_clr),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_hi(rd_hi), .rd_data(rd_data_s),
    .rd_valid(rd_valid_s), .ovf(ovf_s));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_wrap unexpected rd_valid got data %h want no response", rd_data);
      end else begin
        got_exp = exp_q.pop_front();
        if (rd_data !== got_exp) begin
          errors++;
          $display("FAIL rd_wrap got %h want %h at %0t", rd_data, got_exp, $time);
        end
      end
    end
    if (rd_valid_s) begin
      checks++;
      if (exp_s_q.size() == 0) begin
        errors++;
        $display("FAIL rd_sat unexpected rd_valid got data %h want no response", rd_data_s);
      end else begin
        got_exp_s = exp_s_q.pop_front();
        if (rd_data_s !== got_exp_s) begin
          errors++;
          $display("FAIL rd_sat got %h want %h at %0t", rd_data_s, got_exp_s, $time);
        end
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
    cfg_we  = 1'b0;
    cfg_clr = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [1:0] idx, input logic [2:0] s, input logic [1:0] m,
                         input logic clr);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = s; cfg_mode = m; cfg_clr = clr;
  endtask

  task automatic set_rd(input logic [1:0] idx, input logic hi, input logic [31:0] e,
                        input logic [31:0] e_s);
    rd_en = 1'b1; rd_idx = idx; rd_hi = hi;
    exp_q.push_back(e);
    exp_s_q.push_back(e_s);
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [2:0] s, input logic [1:0] m,
                     input logic clr);
    set_cfg(idx, s, m, clr);
    cycle();
  endtask

  task automatic rd(input logic [1:0] idx, input logic hi, input logic [31:0] e,
                    input logic [31:0] e_s);
    set_rd(idx, hi, e, e_s);
    cycle();
  endtask

  // Loads counter 2 of both instances directly (counters 0 and 1 are zeroed).
  task automatic preload(input logic [CW-1:0] v2);
    force dut.ctr   = {v2, {CW{1'b0}}, {CW{1'b0}}};
    force dut_s.ctr = {v2, {CW{1'b0}}, {CW{1'b0}}};
    #1;
    release dut.ctr;
    release dut_s.ctr;
  endtask

  task automatic test_reset();
    evt = 6'b000001; freeze = 0; cfg_we = 0; cfg_clr = 0; rd_en = 0; rd_hi = 0;
    cfg_idx = 0; rd_idx = 0; cfg_sel = 0; cfg_mode = 0;
    #1 reset_n = 1'b0;
    tick(2);
    checks++;
    if (rd_valid !== 1'b0 || rd_valid_s !== 1'b0) begin
      errors++; $display("FAIL reset_rd_valid got %b/%b want 0/0", rd_valid, rd_valid_s);
    end
    checks++;
    if (ovf !== '0 || ovf_s !== '0) begin
      errors++; $display("FAIL reset_ovf got %b/%b want 000/000", ovf, ovf_s);
    end
    checks++;
    if (rd_data !== 32'h0) begin
      errors++; $display("FAIL reset_rd_data got %h want 0", rd_data);
    end
    reset_n = 1'b1;
    tick(3);
    rd(0, 0, 32'd0, 32'd0);
  endtask

  task automatic test_cycle_count();
    cfg(0, 0, 2'b01, 0);
    tick(100);
    rd(0, 0, 32'd100, 32'd100);
    rd(0, 0, 32'd101, 32'd101);
    rd(0, 0, 32'd102, 32'd102);
    cycle();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL idle_rd_valid got %b want 0", rd_valid);
    end
    checks++;
    if (rd_data !== 32'd102) begin
      errors++; $display("FAIL rd_data_hold got %h want %h", rd_data, 32'd102);
    end
    rd(0, 1, 32'd0, 32'd0);
  endtask

  task automatic evt3_pattern();
    for (int k = 0; k < 3; k++) begin
      evt[3] = 1'b1; tick(5);
      evt[3] = 1'b0; tick(3);
    end
  endtask

  task automatic test_edge_mode();
    cfg(1, 3, 2'b10, 0);
    evt3_pattern();
    // Reconfigure to level with clear while reading the same counter: read sees the old value.
    set_cfg(1, 3, 2'b01, 1);
    set_rd(1, 0, 32'd3, 32'd3);
    cycle();
    evt3_pattern();
    rd(1, 0, 32'd15, 32'd15);
    rd(1, 1, 32'd0, 32'd0);
  endtask

  task automatic test_wrap_saturate();
    cfg(2, 0, 2'b01, 0);
    preload({1'b1, 32'hFFFF_FFFE});
    tick(1);
    checks++;
    if (ovf !== 3'b000 || ovf_s !== 3'b000) begin
      errors++; $display("FAIL ovf_before_wrap got %b/%b want 000/000", ovf, ovf_s);
    end
    tick(1);
    checks++;
    if (ovf !== 3'b100 || ovf_s !== 3'b100) begin
      errors++; $display("FAIL ovf_on_wrap got %b/%b want 100/100", ovf, ovf_s);
    end
    tick(1);
    rd(2, 0, 32'd1, 32'hFFFF_FFFF);
    rd(2, 1, 32'd0, 32'd1);
    checks++;
    if (ovf !== 3'b100 || ovf_s !== 3'b100) begin
      errors++; $display("FAIL ovf_sticky got %b/%b want 100/100", ovf, ovf_s);
    end
    preload({1'b1, 32'hFFFF_FFFF});
    cfg(2, 0, 2'b01, 1);
    checks++;
    if (ovf !== 3'b000 || ovf_s !== 3'b000) begin
      errors++; $display("FAIL clr_beats_ovf got %b/%b want 000/000", ovf, ovf_s);
    end
    rd(2, 0, 32'd0, 32'd0);
  endtask

  task automatic test_tear_free();
    preload({1'b0, 32'hFFFF_FFFF});
    rd(2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(2);
    rd(2, 1, 32'd0, 32'd0);
    rd(2, 0, 32'd3, 32'd3);
    rd(2, 1, 32'd1, 32'd1);
    cfg(3, 0, 2'b01, 1);
    rd(2, 0, 32'd6, 32'd6);
    rd(3, 0, 32'd0, 32'd0);
  endtask

  task automatic test_freeze();
    cfg(1, 4, 2'b10, 1);
    cfg(2, 0, 2'b01, 1);
    tick(4);
    freeze = 1'b1;
    rd(2, 0, 32'd4, 32'd4);
    evt[4] = 1'b1;
    tick(8);
    rd(2, 0, 32'd4, 32'd4);
    freeze = 1'b0;
    tick(3);
    rd(2, 0, 32'd7, 32'd7);
    rd(1, 0, 32'd0, 32'd0);
    evt[4] = 1'b0;
    tick(1);
    evt[4] = 1'b1;
    tick(1);
    rd(1, 0, 32'd1, 32'd1);
  endtask

  task automatic test_sel_out_of_range();
    evt = 6'b111111;
    cfg(1, 7, 2'b01, 1);
    tick(5);
    rd(1, 0, 32'd0, 32'd0);
    evt = 6'b000001;
  endtask

  task automatic test_async_reset();
    preload({1'b1, 32'hFFFF_FFFF});
    tick(1);
    checks++;
    if (ovf !== 3'b100 || ovf_s !== 3'b100) begin
      errors++; $display("FAIL ovf_before_reset got %b/%b want 100/100", ovf, ovf_s);
    end
    rd_en = 1'b1; rd_idx = 2; rd_hi = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (rd_valid_s !== 1'b1 || rd_data_s !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL pending_read got %b/%h want 1/ffffffff", rd_valid_s, rd_data_s);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_valid_s !== 1'b0) begin
      errors++; $display("FAIL async_rd_valid got %b/%b want 0/0", rd_valid, rd_valid_s);
    end
    checks++;
    if (ovf !== 3'b000 || ovf_s !== 3'b000) begin
      errors++; $display("FAIL async_ovf got %b/%b want 000/000", ovf, ovf_s);
    end
    checks++;
    if (rd_data_s !== 32'h0) begin
      errors++; $display("FAIL async_rd_data got %h want 0", rd_data_s);
    end
    @(negedge clk);
    rd_en = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    rd(0, 0, 32'd0, 32'd0);
    rd(2, 0, 32'd0, 32'd0);
    rd(2, 1, 32'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_cycle_count();
    test_edge_mode();
    test_wrap_saturate();
    test_tear_free();
    test_freeze();
    test_sel_out_of_range();
    test_async_reset();
    tick(2);
    checks++;
    if (exp_q.size() != 0 || exp_s_q.size() != 0) begin
      errors++;
      $display("FAIL missing_responses got %0d/%0d pending want 0/0", exp_q.size(), exp_s_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
